// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// ALU operations and datapath mux selects.
package rv_ctrl_pkg;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_TRAP     = 4'd11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_decode(input logic [6:0] op);
        logic [1:0] sel;
        case (op)
            OP_SW:   sel = IMM_S;
            OP_BEQ:  sel = IMM_B;
            OP_JAL:  sel = IMM_J;
            default: sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode from the FSM's alu_op and the instruction funct fields.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op_5,
    input  logic       funct7_5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    // Only R-type sets op[5]; addi with imm[10]=1 must stay an add.
                    3'b000:  alu_control = (op_5 & funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I datapath: drives every mux select
// and write strobe, stalling on the memory-ready handshake.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W     = 4,
    parameter bit          TRAP_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       reg_write,
    output logic       instr_done,
    output logic       illegal
);

    localparam logic [STATE_W-1:0] ST_FETCH    = STATE_W'(S_FETCH);
    localparam logic [STATE_W-1:0] ST_DECODE   = STATE_W'(S_DECODE);
    localparam logic [STATE_W-1:0] ST_MEMADR   = STATE_W'(S_MEMADR);
    localparam logic [STATE_W-1:0] ST_MEMREAD  = STATE_W'(S_MEMREAD);
    localparam logic [STATE_W-1:0] ST_MEMWB    = STATE_W'(S_MEMWB);
    localparam logic [STATE_W-1:0] ST_MEMWRITE = STATE_W'(S_MEMWRITE);
    localparam logic [STATE_W-1:0] ST_EXECUTER = STATE_W'(S_EXECUTER);
    localparam logic [STATE_W-1:0] ST_EXECUTEI = STATE_W'(S_EXECUTEI);
    localparam logic [STATE_W-1:0] ST_ALUWB    = STATE_W'(S_ALUWB);
    localparam logic [STATE_W-1:0] ST_BEQ      = STATE_W'(S_BEQ);
    localparam logic [STATE_W-1:0] ST_JAL      = STATE_W'(S_JAL);
    localparam logic [STATE_W-1:0] ST_TRAP     = STATE_W'(S_TRAP);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [1:0]         w_alu_op;
    logic               w_pc_update;
    logic               w_branch;
    logic               w_ir_write;
    logic               w_mem_write;
    logic               w_reg_write;
    logic               w_instr_done;
    logic               w_illegal;
    logic               w_unused_funct7;

    assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = ST_FETCH;
        adr_src      = 1'b0;
        result_src   = RES_ALUOUT;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RS2;
        w_alu_op     = ALUOP_ADD;
        w_ir_write   = 1'b0;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_instr_done = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                alu_src_a    = SRCA_PC;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALU;
                w_ir_write   = mem_ready;
                w_pc_update  = mem_ready;
                w_next_state = mem_ready ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: w_next_state = ST_MEMADR;
                    OP_R:         w_next_state = ST_EXECUTER;
                    OP_I:         w_next_state = ST_EXECUTEI;
                    OP_BEQ:       w_next_state = ST_BEQ;
                    OP_JAL:       w_next_state = ST_JAL;
                    default:      w_next_state = ST_TRAP;
                endcase
            end
            ST_MEMADR: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_IMM;
                w_next_state = op[5] ? ST_MEMWRITE : ST_MEMREAD;
            end
            ST_MEMREAD: begin
                adr_src      = 1'b1;
                w_next_state = mem_ready ? ST_MEMWB : ST_MEMREAD;
            end
            ST_MEMWB: begin
                result_src   = RES_DATA;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            ST_MEMWRITE: begin
                adr_src      = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = mem_ready;
                w_next_state = mem_ready ? ST_FETCH : ST_MEMWRITE;
            end
            ST_EXECUTER: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_RS2;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = ST_ALUWB;
            end
            ST_EXECUTEI: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_IMM;
                w_alu_op     = ALUOP_FUNCT;
                w_next_state = ST_ALUWB;
            end
            ST_ALUWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            ST_BEQ: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_RS2;
                w_alu_op     = ALUOP_SUB;
                w_branch     = 1'b1;
                w_instr_done = 1'b1;
            end
            ST_JAL: begin
                // PC <= alu_out (target from DECODE) while the ALU forms old_pc+4 for rd.
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                w_pc_update  = 1'b1;
                w_next_state = ST_ALUWB;
            end
            ST_TRAP: begin
                w_illegal    = 1'b1;
                w_next_state = TRAP_STICKY ? ST_TRAP : ST_FETCH;
            end
            default: w_next_state = ST_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct3      (funct3),
        .op_5        (op[5]),
        .funct7_5    (funct7[5]),
        .alu_control (alu_control)
    );

    assign imm_src = imm_decode(op);

    // Reset gates the strobes combinationally so they drop the instant rst falls.
    assign pc_write   = rst & (w_pc_update | (w_branch & zero));
    assign ir_write   = rst & w_ir_write;
    assign mem_write  = rst & w_mem_write;
    assign reg_write  = rst & w_reg_write;
    assign instr_done = rst & w_instr_done;
    assign illegal    = rst & w_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; all outputs are
// packed into one vector and compared per cycle against hand-written values.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic       reg_write, instr_done, illegal;

    int errors = 0;
    int checks = 0;

    logic [17:0] obs;
    assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                  alu_src_b, imm_src, alu_control, reg_write, instr_done, illegal};

    multicycle_controller #(.STATE_W(4), .TRAP_STICKY(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .reg_write   (reg_write),
        .instr_done  (instr_done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    // Field order: pcw adr mw irw res a b imm aluc rw done ill
    function automatic logic [17:0] e(input logic pcw, adr, mw, irw,
                                      input logic [1:0] res, a, b, imm,
                                      input logic [2:0] aluc,
                                      input logic rw, done, ill);
        return {pcw, adr, mw, irw, res, a, b, imm, aluc, rw, done, ill};
    endfunction

    task automatic apply_reset();
        rst = 1'b0;
        mem_ready = 1'b0;
        zero = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_ready = 1'b1; zero = 1'b1;
        op = 7'b0000011; funct3 = 3'b000; funct7 = 7'b0000000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== e(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0)) begin
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, obs,
                         e(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0));
                errors++;
            end
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0)) begin
            $display("FAIL reset_first_fetch: got %b expected %b", obs,
                     e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0));
            errors++;
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs !== e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0,0)) begin
            $display("FAIL reset_then_decode: got %b expected %b", obs,
                     e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0,0));
            errors++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        logic [17:0] ev [6];
        ev = '{e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0,0),
               e(0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,0),
               e(0,0,0,0,2'b01,2'b00,2'b00,2'b00,3'b000,1,1,0),
               e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0)};
        apply_reset();
        op = 7'b0000011; funct3 = 3'b010; funct7 = 7'b0000000; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== ev[i]) begin
                $display("FAIL lw[%0d]: got %b expected %b", i, obs, ev[i]);
                errors++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_stall();
        logic [17:0] ev [8];
        logic        mr [8];
        mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ev = '{e(1,0,0,1,2'b10,2'b00,2'b10,2'b01,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0,0),
               e(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0,0),
               e(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0,0),
               e(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,1,0),
               e(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0,0),
               e(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0,0)};
        apply_reset();
        op = 7'b0100011; funct3 = 3'b010; funct7 = 7'b0000000;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            @(negedge clk);
            checks++;
            if (obs !== ev[i]) begin
                $display("FAIL sw_stall[%0d]: got %b expected %b", i, obs, ev[i]);
                errors++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq();
        logic [17:0] ev [7];
        logic        zv [7];
        zv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        ev = '{e(1,0,0,1,2'b10,2'b00,2'b10,2'b10,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0,0),
               e(1,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0,1,0),
               e(1,0,0,1,2'b10,2'b00,2'b10,2'b10,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0,1,0),
               e(1,0,0,1,2'b10,2'b00,2'b10,2'b10,3'b000,0,0,0)};
        apply_reset();
        op = 7'b1100011; funct3 = 3'b000; funct7 = 7'b0000000; mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            zero = zv[i];
            @(negedge clk);
            checks++;
            if (obs !== ev[i]) begin
                $display("FAIL beq[%0d]: got %b expected %b", i, obs, ev[i]);
                errors++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rsub_jal();
        logic [17:0] ev [9];
        logic [6:0]  ov [9];
        ov = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
               7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111};
        ev = '{e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0,0),
               e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,1,0),
               e(1,0,0,1,2'b10,2'b00,2'b10,2'b11,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0,0,0),
               e(1,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b00,2'b00,2'b11,3'b000,1,1,0),
               e(1,0,0,1,2'b10,2'b00,2'b10,2'b11,3'b000,0,0,0)};
        apply_reset();
        funct3 = 3'b000; funct7 = 7'b0100000; mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            op = ov[i];
            @(negedge clk);
            checks++;
            if (obs !== ev[i]) begin
                $display("FAIL rsub_jal[%0d]: got %b expected %b", i, obs, ev[i]);
                errors++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu_funct();
        logic [17:0] ev [12];
        logic [6:0]  ov [12];
        logic [2:0]  f3 [12];
        logic [6:0]  f7 [12];
        for (int i = 0; i < 12; i++) begin
            ov[i] = (i < 8) ? 7'b0010011 : 7'b0110011;
            f3[i] = (i < 4) ? 3'b010 : ((i < 8) ? 3'b000 : 3'b110);
            f7[i] = (i < 4) ? 7'b0000000 : 7'b0100000;
        end
        ev = '{e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b101,0,0,0),
               e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,1,0),
               e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,1,0),
               e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b011,0,0,0),
               e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,1,0)};
        apply_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            op = ov[i]; funct3 = f3[i]; funct7 = f7[i];
            @(negedge clk);
            checks++;
            if (obs !== ev[i]) begin
                $display("FAIL alu_funct[%0d]: got %b expected %b", i, obs, ev[i]);
                errors++;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [17:0] ev [5];
        ev = '{e(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,1),
               e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,1),
               e(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0,1)};
        apply_reset();
        op = 7'b1111111; funct3 = 3'b000; funct7 = 7'b0000000;
        mem_ready = 1'b1; zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== ev[i]) begin
                $display("FAIL illegal[%0d]: got %b expected %b", i, obs, ev[i]);
                errors++;
            end
            @(posedge clk); #1;
        end
        apply_reset();
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== ev[0]) begin
            $display("FAIL illegal_after_reset: got %b expected %b", obs, ev[0]);
            errors++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        logic [17:0] ev [4];
        logic        mr [4];
        mr = '{1'b1, 1'b1, 1'b1, 1'b0};
        ev = '{e(1,0,0,1,2'b10,2'b00,2'b10,2'b01,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0,0),
               e(0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0,0),
               e(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0,0)};
        apply_reset();
        op = 7'b0100011; funct3 = 3'b010; funct7 = 7'b0000000;
        for (int i = 0; i < 4; i++) begin
            mem_ready = mr[i];
            @(negedge clk);
            checks++;
            if (obs !== ev[i]) begin
                $display("FAIL mid_reset_seq[%0d]: got %b expected %b", i, obs, ev[i]);
                errors++;
            end
            @(posedge clk); #1;
        end
        #1;
        checks++;
        if (mem_write !== 1'b1) begin
            $display("FAIL mid_reset_pre: mem_write got %b expected 1", mem_write);
            errors++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== e(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0,0)) begin
            $display("FAIL mid_reset_drop: got %b expected %b", obs,
                     e(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0,0));
            errors++;
        end
        mem_ready = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== ev[0]) begin
            $display("FAIL mid_reset_refetch: got %b expected %b", obs, ev[0]);
            errors++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; mem_ready = 1'b0; zero = 1'b0;
        op = '0; funct3 = '0; funct7 = '0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_rsub_jal();
        test_alu_funct();
        test_illegal();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
